// File: rtl/spi_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_arbiter_pkg
// Purpose  : Shared types and constants for the SPI master arbiter.
//            - state_t    : arbiter FSM states (IDLE, GRANT, DRAIN)
//            - MaxReq     : largest supported requester count
//            - Gated*     : status values shown to requesters not owning the bus
//            - idx_width  : bit width needed to index n requesters (min 1)
// Revision : 1.0 - initial release
// ============================================================================
package spi_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int   MaxReq            = 8;
    localparam logic GatedFull         = 1'b1;
    localparam logic GatedEmpty        = 1'b1;
    localparam logic GatedTransmission = 1'b0;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_picker
// Purpose  : Combinational round-robin selector. Starting just after the
//            last owner and wrapping, returns the first eligible requester.
// Ports    : i_eligible - requesters allowed to win this cycle
//            i_last     - index of the previous owner
//            o_winner   - one-hot winner (all zero when nobody is eligible)
//            o_idx      - index of the winner
// Revision : 1.0 - initial release
// ============================================================================
module rr_picker
    import spi_arbiter_pkg::*;
#(
    parameter int ReqCount = 2,
    parameter int IdxW     = idx_width(ReqCount)
) (
    input  logic [ReqCount-1:0] i_eligible,
    input  logic [IdxW-1:0]     i_last,
    output logic [ReqCount-1:0] o_winner,
    output logic [IdxW-1:0]     o_idx
);

    int   w_cand;
    logic w_found;

    // Offset 1..ReqCount visits every requester once, the last owner last.
    always_comb begin
        o_winner = '0;
        o_idx    = '0;
        w_found  = 1'b0;
        w_cand   = 0;
        for (int i = 1; i <= ReqCount; i++) begin
            w_cand = int'(i_last) + i;
            if (w_cand >= ReqCount) begin
                w_cand = w_cand - ReqCount;
            end
            if (!w_found && i_eligible[IdxW'(w_cand)]) begin
                w_found                  = 1'b1;
                o_winner[IdxW'(w_cand)]  = 1'b1;
                o_idx                    = IdxW'(w_cand);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_arbiter
// Purpose  : Shares one SPI master among ReqCount requesters. Round-robin
//            grant, per-owner strobe/status gating, bus mode latched at grant,
//            and a watchdog that reclaims the master from a stalled owner.
// Ports    : Clk_i/Reset_i        - clock, synchronous active-high reset
//            Req_i/Gnt_o          - per-requester request level / one-hot grant
//            Write_i/ReadNext_i/Data_i, CPOL_i/CPHA_i/LSBFE_i - requester side
//            FIFOFull_o/FIFOEmpty_o/Transmission_o - gated status per requester
//            Timeout_o            - one-cycle pulse on forced release
//            SPI_*_o / SPI_*_i    - SPI master side
// Revision : 1.0 - initial release
// ============================================================================
module spi_arbiter
    import spi_arbiter_pkg::*;
#(
    parameter int ReqCount      = 2,
    parameter int TimeoutCycles = 4096,
    parameter int CntWidth      = 16
) (
    input  logic                  Clk_i,
    input  logic                  Reset_i,
    input  logic [ReqCount-1:0]   Req_i,
    output logic [ReqCount-1:0]   Gnt_o,
    input  logic [ReqCount-1:0]   Write_i,
    input  logic [ReqCount-1:0]   ReadNext_i,
    input  logic [8*ReqCount-1:0] Data_i,
    input  logic [ReqCount-1:0]   CPOL_i,
    input  logic [ReqCount-1:0]   CPHA_i,
    input  logic [ReqCount-1:0]   LSBFE_i,
    output logic [ReqCount-1:0]   FIFOFull_o,
    output logic [ReqCount-1:0]   FIFOEmpty_o,
    output logic [ReqCount-1:0]   Transmission_o,
    output logic                  Timeout_o,
    output logic                  SPI_Write_o,
    output logic                  SPI_ReadNext_o,
    output logic [7:0]            SPI_Data_o,
    output logic                  SPI_CPOL_o,
    output logic                  SPI_CPHA_o,
    output logic                  SPI_LSBFE_o,
    input  logic                  SPI_FIFOFull_i,
    input  logic                  SPI_FIFOEmpty_i,
    input  logic                  SPI_Transmission_i
);

    localparam int                  IdxW    = idx_width(ReqCount);
    localparam logic [CntWidth-1:0] c_limit = CntWidth'(TimeoutCycles - 1);
    localparam logic                c_wd_en = (TimeoutCycles != 0);

    state_t              r_state;
    logic [ReqCount-1:0] r_gnt;
    logic [ReqCount-1:0] r_blocked;
    logic [IdxW-1:0]     r_ptr;      // last owner; current owner while in GRANT
    logic [CntWidth-1:0] r_cnt;
    logic                r_cpol;
    logic                r_cpha;
    logic                r_lsbfe;

    logic [ReqCount-1:0] w_eligible;
    logic [ReqCount-1:0] w_win;
    logic [IdxW-1:0]     w_win_idx;
    logic                w_in_grant;
    logic                w_write;
    logic                w_read;
    logic                w_owner_req;
    logic                w_wd_clr;
    logic                w_timeout;

    assign w_eligible = Req_i & ~r_blocked;

    rr_picker #(
        .ReqCount (ReqCount),
        .IdxW     (IdxW)
    ) u_picker (
        .i_eligible (w_eligible),
        .i_last     (r_ptr),
        .o_winner   (w_win),
        .o_idx      (w_win_idx)
    );

    assign w_in_grant  = (r_state == GRANT);
    assign w_write     = w_in_grant & Write_i[r_ptr] & ~SPI_FIFOFull_i;
    assign w_read      = w_in_grant & ReadNext_i[r_ptr] & ~SPI_FIFOEmpty_i;
    assign w_owner_req = Req_i[r_ptr];
    assign w_wd_clr    = w_write | w_read | SPI_Transmission_i;

    // An owner dropping its request takes precedence over the watchdog.
    assign w_timeout = c_wd_en & w_in_grant & w_owner_req & ~w_wd_clr
                     & (r_cnt == c_limit);

    assign Gnt_o          = r_gnt;
    assign Timeout_o      = w_timeout;
    assign SPI_Write_o    = w_write;
    assign SPI_ReadNext_o = w_read;
    assign SPI_Data_o     = w_in_grant ? Data_i[int'(r_ptr)*8 +: 8] : 8'h00;
    assign SPI_CPOL_o     = r_cpol;
    assign SPI_CPHA_o     = r_cpha;
    assign SPI_LSBFE_o    = r_lsbfe;

    for (genvar k = 0; k < ReqCount; k++) begin : g_status
        logic w_sees;
        assign w_sees            = w_in_grant & r_gnt[k];
        assign FIFOFull_o[k]     = w_sees ? SPI_FIFOFull_i     : GatedFull;
        assign FIFOEmpty_o[k]    = w_sees ? SPI_FIFOEmpty_i    : GatedEmpty;
        assign Transmission_o[k] = w_sees ? SPI_Transmission_i : GatedTransmission;
    end

    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_blocked <= '0;
            r_ptr     <= IdxW'(ReqCount - 1);
            r_cnt     <= '0;
            r_cpol    <= 1'b0;
            r_cpha    <= 1'b0;
            r_lsbfe   <= 1'b0;
        end else begin
            // A timed-out owner stays blocked until it lowers its request.
            r_blocked <= (r_blocked & Req_i) | ({ReqCount{w_timeout}} & r_gnt);
            case (r_state)
                IDLE: begin
                    if (|w_eligible) begin
                        r_state <= GRANT;
                        r_gnt   <= w_win;
                        r_ptr   <= w_win_idx;
                        r_cnt   <= '0;
                        r_cpol  <= CPOL_i[w_win_idx];
                        r_cpha  <= CPHA_i[w_win_idx];
                        r_lsbfe <= LSBFE_i[w_win_idx];
                    end
                end
                GRANT: begin
                    if (!w_owner_req || w_timeout) begin
                        r_state <= DRAIN;
                        r_gnt   <= '0;
                    end else if (w_wd_clr) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (!SPI_Transmission_i) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_arbiter
// Purpose  : Directed self-checking bench for spi_arbiter (2 requesters,
//            8-cycle watchdog).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_arbiter;

    logic        Clk_i = 1'b0;
    logic        Reset_i;
    logic [1:0]  Req_i, Gnt_o, Write_i, ReadNext_i;
    logic [15:0] Data_i;
    logic [1:0]  CPOL_i, CPHA_i, LSBFE_i;
    logic [1:0]  FIFOFull_o, FIFOEmpty_o, Transmission_o;
    logic        Timeout_o, SPI_Write_o, SPI_ReadNext_o;
    logic [7:0]  SPI_Data_o;
    logic        SPI_CPOL_o, SPI_CPHA_o, SPI_LSBFE_o;
    logic        SPI_FIFOFull_i, SPI_FIFOEmpty_i, SPI_Transmission_i;

    int errors = 0;
    int checks = 0;

    always #5 Clk_i = ~Clk_i;

    spi_arbiter #(
        .ReqCount      (2),
        .TimeoutCycles (8),
        .CntWidth      (16)
    ) dut (
        .Clk_i              (Clk_i),
        .Reset_i            (Reset_i),
        .Req_i              (Req_i),
        .Gnt_o              (Gnt_o),
        .Write_i            (Write_i),
        .ReadNext_i         (ReadNext_i),
        .Data_i             (Data_i),
        .CPOL_i             (CPOL_i),
        .CPHA_i             (CPHA_i),
        .LSBFE_i            (LSBFE_i),
        .FIFOFull_o         (FIFOFull_o),
        .FIFOEmpty_o        (FIFOEmpty_o),
        .Transmission_o     (Transmission_o),
        .Timeout_o          (Timeout_o),
        .SPI_Write_o        (SPI_Write_o),
        .SPI_ReadNext_o     (SPI_ReadNext_o),
        .SPI_Data_o         (SPI_Data_o),
        .SPI_CPOL_o         (SPI_CPOL_o),
        .SPI_CPHA_o         (SPI_CPHA_o),
        .SPI_LSBFE_o        (SPI_LSBFE_o),
        .SPI_FIFOFull_i     (SPI_FIFOFull_i),
        .SPI_FIFOEmpty_i    (SPI_FIFOEmpty_i),
        .SPI_Transmission_i (SPI_Transmission_i)
    );

    task automatic tick;
        @(posedge Clk_i);
        #1;
    endtask

    task automatic clear_inputs;
        Req_i = '0; Write_i = '0; ReadNext_i = '0; Data_i = '0;
        CPOL_i = '0; CPHA_i = '0; LSBFE_i = '0;
        SPI_FIFOFull_i = 1'b0; SPI_FIFOEmpty_i = 1'b0; SPI_Transmission_i = 1'b0;
    endtask

    task automatic do_reset;
        clear_inputs();
        Reset_i = 1'b1;
        tick(); tick();
        Reset_i = 1'b0;
    endtask

    task automatic test_reset;
        clear_inputs();
        Reset_i = 1'b1;
        SPI_Transmission_i = 1'b1;
        tick(); tick();
        checks++; if (Gnt_o !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b expected 00", Gnt_o); end
        checks++; if (Timeout_o !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", Timeout_o); end
        checks++; if ({SPI_Write_o, SPI_ReadNext_o, SPI_Data_o} !== 10'h000) begin errors++; $display("FAIL reset_strobes: got %h expected 000", {SPI_Write_o, SPI_ReadNext_o, SPI_Data_o}); end
        checks++; if ({SPI_CPOL_o, SPI_CPHA_o, SPI_LSBFE_o} !== 3'b000) begin errors++; $display("FAIL reset_mode: got %b expected 000", {SPI_CPOL_o, SPI_CPHA_o, SPI_LSBFE_o}); end
        checks++; if ({FIFOFull_o, FIFOEmpty_o, Transmission_o} !== 6'b111100) begin errors++; $display("FAIL reset_status: got %b expected 111100", {FIFOFull_o, FIFOEmpty_o, Transmission_o}); end
        Reset_i = 1'b0;
        SPI_Transmission_i = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        do_reset();
        Req_i = 2'b01; CPOL_i = 2'b01;
        tick();
        checks++; if (Gnt_o !== 2'b01) begin errors++; $display("FAIL basic_gnt: got %b expected 01", Gnt_o); end
        checks++; if (SPI_CPOL_o !== 1'b1) begin errors++; $display("FAIL basic_cpol: got %b expected 1", SPI_CPOL_o); end
        Write_i = 2'b01; Data_i = 16'h33A5; SPI_Transmission_i = 1'b1;
        #1;
        checks++; if (SPI_Write_o !== 1'b1) begin errors++; $display("FAIL basic_write: got %b expected 1", SPI_Write_o); end
        checks++; if (SPI_Data_o !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h expected a5", SPI_Data_o); end
        checks++; if (FIFOFull_o !== 2'b10) begin errors++; $display("FAIL basic_full_gate: got %b expected 10", FIFOFull_o); end
        checks++; if (Transmission_o !== 2'b01) begin errors++; $display("FAIL basic_trans_gate: got %b expected 01", Transmission_o); end
        Write_i = '0; Req_i = '0; SPI_Transmission_i = 1'b0;
        tick();
        checks++; if (Gnt_o !== 2'b00) begin errors++; $display("FAIL basic_release: got %b expected 00", Gnt_o); end
        tick();
    endtask

    task automatic test_rotation;
        int n;
        logic [1:0] exp_gnt;
        do_reset();
        Req_i = 2'b11;
        for (int g = 0; g < 4; g++) begin
            exp_gnt = (g % 2 == 0) ? 2'b01 : 2'b10;
            n = 0;
            do begin
                tick();
                n++;
            end while (Gnt_o == 2'b00 && n < 10);
            checks++; if (Gnt_o !== exp_gnt) begin errors++; $display("FAIL rot_gnt%0d: got %b expected %b", g, Gnt_o, exp_gnt); end
            checks++; if (n !== ((g == 0) ? 1 : 2)) begin errors++; $display("FAIL rot_gap%0d: got %0d expected %0d", g, n, (g == 0) ? 1 : 2); end
            tick(); tick();
            Req_i = Req_i & ~exp_gnt;
            tick();
            checks++; if (Gnt_o !== 2'b00) begin errors++; $display("FAIL rot_release%0d: got %b expected 00", g, Gnt_o); end
            Req_i = 2'b11;
        end
        Req_i = '0;
        tick(); tick(); tick();
    endtask

    task automatic test_drain;
        do_reset();
        Req_i = 2'b01; CPOL_i = 2'b01;
        tick();
        checks++; if (Gnt_o !== 2'b01) begin errors++; $display("FAIL drain_gnt0: got %b expected 01", Gnt_o); end
        Req_i = 2'b10; CPOL_i = 2'b00; Write_i = 2'b11; SPI_Transmission_i = 1'b1;
        #1;
        checks++; if (SPI_Write_o !== 1'b1) begin errors++; $display("FAIL drain_last_strobe: got %b expected 1", SPI_Write_o); end
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++; if ({Gnt_o, SPI_Write_o, SPI_CPOL_o} !== 4'b0001) begin errors++; $display("FAIL drain_hold%0d: got %b expected 0001", i, {Gnt_o, SPI_Write_o, SPI_CPOL_o}); end
            checks++; if (Transmission_o !== 2'b00) begin errors++; $display("FAIL drain_trans_gate%0d: got %b expected 00", i, Transmission_o); end
            tick();
        end
        SPI_Transmission_i = 1'b0;
        #1;
        checks++; if ({Gnt_o, SPI_CPOL_o} !== 3'b001) begin errors++; $display("FAIL drain_exit: got %b expected 001", {Gnt_o, SPI_CPOL_o}); end
        tick();
        checks++; if (Gnt_o !== 2'b00) begin errors++; $display("FAIL drain_idle: got %b expected 00", Gnt_o); end
        tick();
        checks++; if ({Gnt_o, SPI_CPOL_o} !== 3'b100) begin errors++; $display("FAIL drain_next_gnt: got %b expected 100", {Gnt_o, SPI_CPOL_o}); end
        Req_i = '0; Write_i = '0;
        tick(); tick();
    endtask

    task automatic test_timeout;
        logic exp_to;
        do_reset();
        Req_i = 2'b01;
        tick();
        for (int i = 1; i <= 8; i++) begin
            exp_to = (i == 8);
            checks++; if ({Gnt_o, Timeout_o} !== {2'b01, exp_to}) begin errors++; $display("FAIL to_cycle%0d: got %b expected %b", i, {Gnt_o, Timeout_o}, {2'b01, exp_to}); end
            tick();
        end
        checks++; if ({Gnt_o, Timeout_o} !== 3'b000) begin errors++; $display("FAIL to_release: got %b expected 000", {Gnt_o, Timeout_o}); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (Gnt_o !== 2'b00) begin errors++; $display("FAIL to_blocked%0d: got %b expected 00", i, Gnt_o); end
        end
        Req_i = 2'b00;
        tick();
        Req_i = 2'b01;
        tick();
        checks++; if (Gnt_o !== 2'b01) begin errors++; $display("FAIL to_regrant: got %b expected 01", Gnt_o); end
        for (int i = 0; i < 7; i++) tick();
        checks++; if (Timeout_o !== 1'b1) begin errors++; $display("FAIL to_boundary_arm: got %b expected 1", Timeout_o); end
        Req_i = 2'b00;
        #1;
        checks++; if (Timeout_o !== 1'b0) begin errors++; $display("FAIL to_drop_same_cycle: got %b expected 0", Timeout_o); end
        tick();
        checks++; if (Gnt_o !== 2'b00) begin errors++; $display("FAIL to_drop_release: got %b expected 00", Gnt_o); end
        Req_i = 2'b01;
        tick(); tick();
        checks++; if (Gnt_o !== 2'b01) begin errors++; $display("FAIL to_not_blocked: got %b expected 01", Gnt_o); end
        Req_i = '0;
        tick(); tick(); tick();
    endtask

    task automatic test_gating;
        do_reset();
        Req_i = 2'b01;
        tick();
        SPI_Transmission_i = 1'b1;
        Write_i = 2'b01; SPI_FIFOFull_i = 1'b1;
        #1;
        checks++; if (SPI_Write_o !== 1'b0) begin errors++; $display("FAIL gate_write_full: got %b expected 0", SPI_Write_o); end
        SPI_FIFOFull_i = 1'b0;
        #1;
        checks++; if (SPI_Write_o !== 1'b1) begin errors++; $display("FAIL gate_write_ok: got %b expected 1", SPI_Write_o); end
        Write_i = 2'b10;
        #1;
        checks++; if (SPI_Write_o !== 1'b0) begin errors++; $display("FAIL gate_write_nonowner: got %b expected 0", SPI_Write_o); end
        Write_i = 2'b00; ReadNext_i = 2'b01; SPI_FIFOEmpty_i = 1'b1;
        #1;
        checks++; if (SPI_ReadNext_o !== 1'b0) begin errors++; $display("FAIL gate_read_empty: got %b expected 0", SPI_ReadNext_o); end
        SPI_FIFOEmpty_i = 1'b0;
        #1;
        checks++; if (SPI_ReadNext_o !== 1'b1) begin errors++; $display("FAIL gate_read_ok: got %b expected 1", SPI_ReadNext_o); end
        ReadNext_i = 2'b10;
        #1;
        checks++; if (SPI_ReadNext_o !== 1'b0) begin errors++; $display("FAIL gate_read_nonowner: got %b expected 0", SPI_ReadNext_o); end
        Data_i = 16'h5A3C;
        #1;
        checks++; if (SPI_Data_o !== 8'h3C) begin errors++; $display("FAIL gate_data: got %h expected 3c", SPI_Data_o); end
        checks++; if ({FIFOFull_o, FIFOEmpty_o} !== 4'b1010) begin errors++; $display("FAIL gate_status: got %b expected 1010", {FIFOFull_o, FIFOEmpty_o}); end
        clear_inputs();
        tick(); tick(); tick();
    endtask

    task automatic test_reset_midgrant;
        do_reset();
        Req_i = 2'b11; CPOL_i = 2'b11;
        tick();
        checks++; if ({Gnt_o, SPI_CPOL_o} !== 3'b011) begin errors++; $display("FAIL rmid_gnt: got %b expected 011", {Gnt_o, SPI_CPOL_o}); end
        Write_i = 2'b01;
        Reset_i = 1'b1;
        tick();
        checks++; if ({Gnt_o, SPI_CPOL_o, SPI_Write_o} !== 4'b0000) begin errors++; $display("FAIL rmid_reset: got %b expected 0000", {Gnt_o, SPI_CPOL_o, SPI_Write_o}); end
        Reset_i = 1'b0; Write_i = 2'b00;
        tick();
        checks++; if (Gnt_o !== 2'b01) begin errors++; $display("FAIL rmid_priority: got %b expected 01", Gnt_o); end
        clear_inputs();
        tick(); tick();
    endtask

    initial begin
        Reset_i = 1'b1;
        clear_inputs();
        test_reset();
        test_basic();
        test_rotation();
        test_drain();
        test_timeout();
        test_gating();
        test_reset_midgrant();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
